// File: rtl/flight_physics_fx.sv
// Bird-motion engine for Flappy-VGA: sub-pixel Y position/velocity with IDLE/FLY/DEAD sequencing.
// Optional feature: define TERMINAL_VEL_EN to clamp downward speed to TERM_VEL after each gravity add.
module flight_physics_fx #(
  parameter int Y_W      = 10,
  parameter int FRAC_W   = 4,
  parameter int V_W      = 10,
  parameter int START_X  = 100,
  parameter int START_Y  = 240,
  parameter int CEIL_Y   = 0,
  parameter int FLOOR_Y  = 440,
  parameter int JUMP_VEL = 72,
  parameter int GRAVITY  = 6
`ifdef TERMINAL_VEL_EN
  ,
  parameter int TERM_VEL = 128
`endif
) (
  input  logic                  Clk,
  input  logic                  reset_n,
  input  logic                  Start,
  input  logic                  Ack,
  input  logic                  BtnPress,
  input  logic                  FrameTick,
  input  logic                  Collide,
  output logic [Y_W-1:0]        Bird_X,
  output logic [Y_W-1:0]        Bird_Y,
  output logic signed [V_W-1:0] VertSpeed,
  output logic                  Flying,
  output logic                  Dead
);

  localparam int P_W   = Y_W + FRAC_W;
  localparam int ACC_W = P_W + 2;

  localparam logic [P_W-1:0]          START_POS = P_W'(START_Y * (2 ** FRAC_W));
  localparam logic [P_W-1:0]          CEIL_POS  = P_W'(CEIL_Y * (2 ** FRAC_W));
  localparam logic [P_W-1:0]          FLOOR_POS = P_W'(FLOOR_Y * (2 ** FRAC_W));
  localparam logic signed [ACC_W-1:0] CEIL_ACC  = ACC_W'(CEIL_Y * (2 ** FRAC_W));
  localparam logic signed [ACC_W-1:0] FLOOR_ACC = ACC_W'(FLOOR_Y * (2 ** FRAC_W));
  localparam logic signed [V_W-1:0]   FLAP_VEL  = V_W'(-JUMP_VEL);
`ifdef TERMINAL_VEL_EN
  localparam logic signed [V_W:0]     VEL_LIM   = (V_W + 1)'(TERM_VEL);
`else
  localparam logic signed [V_W:0]     VEL_LIM   = (V_W + 1)'((2 ** (V_W - 1)) - 1);
`endif

  typedef enum logic [1:0] {S_IDLE, S_FLY, S_DEAD} state_t;

  state_t                  state;
  logic [P_W-1:0]          pos;
  logic signed [V_W-1:0]   vel;
  logic                    flap_pend;
  logic                    btn_q;

  logic                    btn_rise;
  logic signed [ACC_W-1:0] pos_sum;
  logic signed [V_W:0]     grav_sum;
  logic signed [V_W-1:0]   vel_fall;
  logic                    hit_ceil;
  logic                    hit_floor;
  logic [P_W-1:0]          pos_next;
  logic signed [V_W-1:0]   vel_next;

  assign btn_rise = BtnPress & ~btn_q;

  // Two guard bits above the position let a step past either limit be seen before clamping.
  assign pos_sum  = $signed({2'b00, pos}) + $signed({{(ACC_W - V_W){vel[V_W-1]}}, vel});
  assign grav_sum = $signed({vel[V_W-1], vel}) + $signed((V_W + 1)'(GRAVITY));
  assign vel_fall = (grav_sum > VEL_LIM) ? VEL_LIM[V_W-1:0] : grav_sum[V_W-1:0];
  assign hit_ceil  = (pos_sum < CEIL_ACC);
  assign hit_floor = (pos_sum >= FLOOR_ACC);

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    pos_next = pos_sum[P_W-1:0];
    vel_next = (state == S_FLY && (flap_pend || btn_rise)) ? FLAP_VEL : vel_fall;
    if (hit_ceil) begin
      pos_next = CEIL_POS;
      vel_next = '0;
    end else if (hit_floor) begin
      pos_next = FLOOR_POS;
      vel_next = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      pos       <= START_POS;
      vel       <= '0;
      flap_pend <= 1'b0;
      btn_q     <= 1'b0;
      Flying    <= 1'b0;
      Dead      <= 1'b0;
    end else begin
      btn_q <= BtnPress;
      case (state)
        S_IDLE: begin
          pos       <= START_POS;
          vel       <= '0;
          flap_pend <= 1'b0;
          if (Start) begin
            state  <= S_FLY;
            Flying <= 1'b1;
          end
        end
        S_FLY: begin
          if (FrameTick) begin
            pos       <= pos_next;
            vel       <= vel_next;
            flap_pend <= 1'b0;
          end else if (btn_rise) begin
            flap_pend <= 1'b1;
          end
          // A coincident tick has already been applied above; the hit only changes state.
          if (Collide || (FrameTick && hit_floor)) begin
            state     <= S_DEAD;
            Flying    <= 1'b0;
            Dead      <= 1'b1;
            flap_pend <= 1'b0;
          end
        end
        S_DEAD: begin
          flap_pend <= 1'b0;
          if (Ack) begin
            state <= S_IDLE;
            Dead  <= 1'b0;
            pos   <= START_POS;
            vel   <= '0;
          end else if (FrameTick) begin
            pos <= pos_next;
            vel <= vel_next;
          end
        end
        default: begin
          state  <= S_IDLE;
          Flying <= 1'b0;
          Dead   <= 1'b0;
        end
      endcase
    end
  end

  assign Bird_X    = Y_W'(START_X);
  assign Bird_Y    = pos[P_W-1:FRAC_W];
  assign VertSpeed = vel;

endmodule

// File: tb/tb_flight_physics_fx.sv
// Scoreboard bench for flight_physics_fx: a frame-level reference model predicts every cycle,
// a monitor compares each prediction one edge later, plus directed checks of the named scenarios.
module tb_flight_physics_fx;

  localparam int START_Y  = 240;
  localparam int FLOOR_Y  = 440;
  localparam int ONE      = 16;     // 1 pixel in Q4
  localparam int JUMP_VEL = 72;
  localparam int GRAVITY  = 6;
  localparam int VMAX     = 511;
`ifdef TERMINAL_VEL_EN
  localparam int SPEED_22 = 128;
`else
  localparam int SPEED_22 = 132;
`endif

  logic       Clk = 1'b0;
  logic       reset_n;
  logic       Start, Ack, BtnPress, FrameTick, Collide;
  logic [9:0] Bird_X, Bird_Y;
  logic signed [9:0] VertSpeed;
  logic       Flying, Dead;

  flight_physics_fx dut (
    .Clk(Clk), .reset_n(reset_n), .Start(Start), .Ack(Ack), .BtnPress(BtnPress),
    .FrameTick(FrameTick), .Collide(Collide), .Bird_X(Bird_X), .Bird_Y(Bird_Y),
    .VertSpeed(VertSpeed), .Flying(Flying), .Dead(Dead)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int y;
    int vel;
    bit fly;
    bit dead;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: position in 1/16 pixel, velocity in 1/16 pixel/frame.
  typedef enum {M_IDLE, M_FLY, M_DEAD} mstate_t;
  mstate_t m_st;
  int      m_pos, m_vel;
  bit      m_pend, m_btn;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int fall(input int v);
    int r = v + GRAVITY;
    if (r > VMAX) r = VMAX;
`ifdef TERMINAL_VEL_EN
    if (r > 128) r = 128;
`endif
    return r;
  endfunction

  function automatic void model_reset();
    m_st = M_IDLE; m_pos = START_Y * ONE; m_vel = 0; m_pend = 0; m_btn = 0;
  endfunction

  // Advance one frame of physics; returns 1 when the bird reached the floor.
  function automatic bit model_physics(input bit flap);
    int np = m_pos + m_vel;
    int nv = flap ? -JUMP_VEL : fall(m_vel);
    bit floor_hit = 0;
    if (np < 0) begin
      np = 0; nv = 0;
    end else if (np >= FLOOR_Y * ONE) begin
      np = FLOOR_Y * ONE; nv = 0; floor_hit = 1;
    end
    m_pos = np; m_vel = nv;
    return floor_hit;
  endfunction

  function automatic void model_step(input bit st, ak, bt, tk, co);
    bit edge_seen = bt && !m_btn;
    m_btn = bt;
    case (m_st)
      M_IDLE: begin
        m_pos = START_Y * ONE; m_vel = 0; m_pend = 0;
        if (st) m_st = M_FLY;
      end
      M_FLY: begin
        if (tk) begin
          if (model_physics(m_pend || edge_seen)) m_st = M_DEAD;
          m_pend = 0;
        end else if (edge_seen) begin
          m_pend = 1;
        end
        if (co) m_st = M_DEAD;
      end
      default: begin
        m_pend = 0;
        if (ak) begin
          m_st = M_IDLE; m_pos = START_Y * ONE; m_vel = 0;
        end else if (tk) begin
          void'(model_physics(1'b0));
        end
      end
    endcase
  endfunction

  function automatic void push_expect();
    exp_t e;
    e.y = m_pos / ONE; e.vel = m_vel; e.fly = (m_st == M_FLY); e.dead = (m_st == M_DEAD);
    exp_q.push_back(e);
  endfunction

  function automatic void drive(input bit st, ak, bt, tk, co);
    Start = st; Ack = ak; BtnPress = bt; FrameTick = tk; Collide = co;
    model_step(st, ak, bt, tk, co);
    push_expect();
  endfunction

  task automatic cyc(input bit st, ak, bt, tk, co);
    @(negedge Clk);
    drive(st, ak, bt, tk, co);
  endtask

  task automatic frame(input bit bt);
    repeat (3) cyc(0, 0, bt, 0, 0);
    cyc(0, 0, bt, 1, 0);
  endtask

  // Wait for the edge that applies the last driven cycle, then settle.
  task automatic settle();
    @(posedge Clk);
    #3;
  endtask

  task automatic apply_reset();
    @(negedge Clk);
    reset_n = 1'b0;
    Start = 0; Ack = 0; BtnPress = 0; FrameTick = 0; Collide = 0;
    #1;
    check("reset Bird_Y", int'(Bird_Y), START_Y);
    check("reset VertSpeed", int'(VertSpeed), 0);
    check("reset Flying", int'(Flying), 0);
    check("reset Dead", int'(Dead), 0);
    check("reset Bird_X", int'(Bird_X), 100);
    exp_q.delete();
    model_reset();
    @(negedge Clk);
    reset_n = 1'b1;
    drive(0, 0, 0, 0, 0);
  endtask

  // Monitor: every cycle out of reset the DUT presents a new registered state.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #2;
      if (reset_n === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb Bird_Y", int'(Bird_Y), e.y);
        check("sb VertSpeed", int'(VertSpeed), e.vel);
        check("sb Flying", int'(Flying), int'(e.fly));
        check("sb Dead", int'(Dead), int'(e.dead));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit reached;
    reset_n = 1'b0;
    Start = 0; Ack = 0; BtnPress = 0; FrameTick = 0; Collide = 0;
    model_reset();
    #12;
    apply_reset();

    // Two gravity frames from rest.
    cyc(1, 0, 0, 0, 0);
    settle();
    check("start Flying", int'(Flying), 1);
    frame(0); settle();
    check("tick1 VertSpeed", int'(VertSpeed), 6);
    frame(0); settle();
    check("tick2 VertSpeed", int'(VertSpeed), 12);
    check("tick2 Bird_Y", int'(Bird_Y), 240);

    // Held button spanning two ticks flaps once.
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 1, (i == 5 || i == 15), 0);
      if (i == 5)  begin settle(); check("hold tick1 VertSpeed", int'(VertSpeed), -JUMP_VEL); end
      if (i == 15) begin settle(); check("hold tick2 VertSpeed", int'(VertSpeed), -JUMP_VEL + GRAVITY); end
    end
    cyc(0, 0, 0, 0, 0);

    // Repeated flaps pin the bird to the ceiling without killing it.
    for (int f = 0; f < 70; f++) begin
      cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0);
    end
    settle();
    check("ceiling Bird_Y", int'(Bird_Y), 0);
    check("ceiling Flying", int'(Flying), 1);

    // Free fall to the floor.
    reached = 0;
    for (int f = 0; f < 200 && !reached; f++) begin
      frame(0); settle();
      reached = (Dead === 1'b1);
    end
    check("floor reached Dead", int'(reached), 1);
    check("floor Bird_Y", int'(Bird_Y), FLOOR_Y);
    check("floor VertSpeed", int'(VertSpeed), 0);
    frame(1); frame(0);
    cyc(0, 1, 0, 1, 0); settle();
    check("ack Bird_Y", int'(Bird_Y), START_Y);
    check("ack Dead", int'(Dead), 0);

    // Collide pulse kills on the next edge.
    cyc(1, 0, 0, 0, 0);
    frame(0); frame(0);
    cyc(0, 0, 0, 0, 1); settle();
    check("collide Dead", int'(Dead), 1);
    check("collide Flying", int'(Flying), 0);
    cyc(0, 1, 0, 0, 0);

    // 22 frames of free fall: terminal-velocity boundary.
    cyc(1, 0, 0, 0, 0);
    repeat (22) frame(0);
    settle();
    check("22 ticks VertSpeed", int'(VertSpeed), SPEED_22);

    // Async reset mid-flight once the bird is around Y=300.
    apply_reset();
    cyc(1, 0, 0, 0, 0);
    reached = 0;
    for (int f = 0; f < 60 && !reached; f++) begin
      frame(0); settle();
      reached = (int'(Bird_Y) >= 300);
    end
    check("reach Y300", int'(reached), 1);
    apply_reset();

    // Randomised play.
    begin
      bit bt = 0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 5) == 0) bt = ~bt;
        cyc($urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0, bt,
            $urandom_range(0, 3) == 0, $urandom_range(0, 99) == 0);
      end
    end

    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge Clk);
    check("scoreboard drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
